sensor_req_responder: RTL and testbench
=======================================

Name: sensor_req_responder

Overview:
- Remote end of the menu request link.
- Receives the 2-byte request frame from the UART RX path: header {4'b0000, sensor[1:0], sala[1:0]}, then payload 0x00.
- Validates and decodes the frame, then replies through the UART TX path with 2 bytes: header echo, then the selected sensor value (or 0x00 ack for a room-only request).
- Sits between uart_rx/uart_tx and the sensor sampling registers.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- TIMEOUT_CYCLES, CLK_FREQ/100, maximum cycles allowed between header and payload bytes (10 ms).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle pulse; rx_byte is valid this cycle.
- rx_byte  in  8  received byte.
- tx_done_pulse  in  1  one-cycle pulse when uart_tx has finished the current byte.
- s1_temp, s1_hum, s2_temp, s2_hum  in  8 each  live sensor values for room 1 and room 2.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_byte.
- tx_byte  out  8  byte to transmit; held stable from tx_start until tx_done_pulse.
- req_sala  out  2  sala field of the last valid frame.
- req_sensor  out  2  sensor field of the last valid frame.
- busy  out  1  high from header acceptance until reply completion.
- frame_err  out  1  one-cycle pulse on a rejected frame or a timeout.
- err_count  out  8  saturating count of frame_err pulses.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; tx_start=0, tx_byte=0x00, req_sala=0, req_sensor=0, busy=0, frame_err=0, err_count=0; timeout counter=0; snapshot registers=0. Reset mid-reply aborts immediately; no further tx_start is issued.
- All outputs are registered.
- States: IDLE, WAIT_PL, SEND_H, WAIT_H, SEND_D, WAIT_D.
- IDLE:
  - rx_valid stores rx_byte as the header, sets busy=1, clears the timeout counter, and moves to WAIT_PL.
- WAIT_PL:
  - The timeout counter increments every cycle.
  - Counter reaching TIMEOUT_CYCLES-1 with no rx_valid: frame_err pulse, state -> IDLE, busy=0.
  - rx_valid: validate the frame.
  - Valid frame requires all of: header[7:4]==0, sala in {01,10}, sensor in {00,01,10}, payload==0x00.
  - Invalid: frame_err pulse, state -> IDLE, busy=0, req_* unchanged.
  - Valid: req_sala/req_sensor updated; the data byte is snapshotted on the same edge; state -> SEND_H.
  - rx_valid on the same cycle as the timeout terminal count: the byte wins and is validated.
- Data byte mux (at snapshot):
  - sensor=00 -> 0x00 ack.
  - sala=01: sensor=01 -> s1_temp; sensor=10 -> s1_hum.
  - sala=10: sensor=01 -> s2_temp; sensor=10 -> s2_hum.
- SEND_H: drive tx_start=1 for exactly one cycle with tx_byte=header; move to WAIT_H. tx_start rises on the cycle after the payload's rx_valid cycle.
- WAIT_H: on tx_done_pulse -> SEND_D.
- SEND_D: tx_start=1 for one cycle with tx_byte=snapshot; move to WAIT_D.
- WAIT_D: on tx_done_pulse -> IDLE, busy=0, tx_byte=0x00.
- tx_done_pulse outside WAIT_H/WAIT_D: ignored.
- rx_valid during SEND_*/WAIT_*: byte dropped, no error. The request/response protocol is half-duplex.
- Sensor inputs changing after the snapshot do not affect the reply in flight.
- err_count saturates at 0xFF and never wraps.

Decomposition:
- Shared package health_link_pkg:
  - frame field constants: SALA_1=2'b01, SALA_2=2'b10, SENS_NONE=2'b00, SENS_TEMP=2'b01, SENS_HUM=2'b10, PAYLOAD_REQ=8'h00;
  - state enum typedef;
  - function frame_valid(header, payload).
- One natural sub-module: link_timeout_timer. It has load/run inputs, terminal-count output and TIMEOUT_CYCLES parameter, and is reused by the menu side.
- The data mux stays inline.

Test Plan:
- Valid temperature request, room 1: rx 0x05 then 0x00, s1_temp=0x1A -> tx_start 1 cycle after the 2nd rx_valid with tx_byte=0x05; after tx_done_pulse, second tx_start with tx_byte=0x1A; req_sala=01, req_sensor=01; busy falls after the 2nd tx_done_pulse.
- Room-only request: rx 0x02, 0x00 -> reply 0x02, then 0x00; s2_* values ignored.
- Invalid frames: 0x13/0x00 (nonzero upper nibble), 0x03/0x00 (sala=11), 0x0A/0x55 (bad payload) -> one frame_err pulse each, no tx_start, err_count=3, req_* unchanged.
- Timeout: rx 0x06, then no byte for TIMEOUT_CYCLES (reduced to 50 in the bench) -> frame_err on cycle 50, state IDLE; a subsequent full valid frame is answered normally.
- Snapshot and drop behaviour: change s2_hum from 0x40 to 0x41 after frame 0x0A/0x00 is accepted, and inject rx_valid during WAIT_H -> second reply byte is 0x40; the injected byte produces no error and no extra tx.
- Reset and saturation: assert rst_n=0 while in WAIT_D -> all outputs at reset values, no further tx_start. Separately, drive 300 invalid frames -> err_count holds at 0xFF.

Source files
------------

// File: rtl/health_link_pkg.sv
// Shared definitions for the menu request link: frame fields, FSM states and frame validation.
package health_link_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] SALA_1    = 2'b01;
  localparam logic [1:0] SALA_2    = 2'b10;
  localparam logic [1:0] SENS_NONE = 2'b00;
  localparam logic [1:0] SENS_TEMP = 2'b01;
  localparam logic [1:0] SENS_HUM  = 2'b10;
  localparam logic [BYTE_W-1:0] PAYLOAD_REQ = 8'h00;
  localparam logic [BYTE_W-1:0] ACK_BYTE    = 8'h00;

  typedef struct packed {
    logic [3:0] rsvd;
    logic [1:0] sensor;
    logic [1:0] sala;
  } req_hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PL,
    ST_SEND_H,
    ST_WAIT_H,
    ST_SEND_D,
    ST_WAIT_D
  } link_state_e;

  // A request is accepted only for a known room, a known sensor and the fixed payload.
  function automatic logic frame_valid(input logic [BYTE_W-1:0] header,
                                       input logic [BYTE_W-1:0] payload);
    req_hdr_t h;
    h = req_hdr_t'(header);
    return (h.rsvd == 4'h0) &&
           ((h.sala == SALA_1) || (h.sala == SALA_2)) &&
           ((h.sensor == SENS_NONE) || (h.sensor == SENS_TEMP) || (h.sensor == SENS_HUM)) &&
           (payload == PAYLOAD_REQ);
  endfunction

endpackage

// File: rtl/link_timeout_timer.sv
// Inter-byte timeout counter: load clears, run counts up, tc_c flags the terminal count.
module link_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic run_i,
  output logic tc_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_c = (cnt_q == TC_VAL);

  // Count holds at terminal value so it never wraps back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (run_i && !tc_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sensor_req_responder.sv
// Remote end of the menu request link: decodes 2-byte requests and replies with header echo plus sensor value.
module sensor_req_responder
  import health_link_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       tx_done_pulse,
  input  logic [7:0] s1_temp,
  input  logic [7:0] s1_hum,
  input  logic [7:0] s2_temp,
  input  logic [7:0] s2_hum,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  output logic [1:0] req_sala,
  output logic [1:0] req_sensor,
  output logic       busy,
  output logic       frame_err,
  output logic [7:0] err_count
);

  link_state_e state_q, state_d;
  req_hdr_t    hdr_q, hdr_d;
  logic [7:0]  snap_q, snap_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [1:0]  req_sala_q, req_sala_d;
  logic [1:0]  req_sensor_q, req_sensor_d;
  logic        busy_q, busy_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        tmr_load_c, tmr_run_c, tmr_tc_c;
  logic [7:0]  data_sel_c;

  link_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load_c),
    .run_i  (tmr_run_c),
    .tc_c   (tmr_tc_c)
  );

  // Reply data byte, chosen from the stored header at snapshot time.
  always_comb begin
    data_sel_c = ACK_BYTE;
    if (hdr_q.sensor == SENS_TEMP) begin
      data_sel_c = (hdr_q.sala == SALA_1) ? s1_temp : s2_temp;
    end else if (hdr_q.sensor == SENS_HUM) begin
      data_sel_c = (hdr_q.sala == SALA_1) ? s1_hum : s2_hum;
    end
  end

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    snap_d       = snap_q;
    tx_start_d   = 1'b0;
    tx_byte_d    = tx_byte_q;
    req_sala_d   = req_sala_q;
    req_sensor_d = req_sensor_q;
    busy_d       = busy_q;
    frame_err_d  = 1'b0;
    tmr_load_c   = 1'b0;
    tmr_run_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          hdr_d      = req_hdr_t'(rx_byte);
          busy_d     = 1'b1;
          tmr_load_c = 1'b1;
          state_d    = ST_WAIT_PL;
        end
      end
      ST_WAIT_PL: begin
        tmr_run_c = 1'b1;
        // A payload byte arriving on the terminal-count cycle still gets validated.
        if (rx_valid) begin
          if (frame_valid(8'(hdr_q), rx_byte)) begin
            req_sala_d   = hdr_q.sala;
            req_sensor_d = hdr_q.sensor;
            snap_d       = data_sel_c;
            tx_start_d   = 1'b1;
            tx_byte_d    = 8'(hdr_q);
            state_d      = ST_SEND_H;
          end else begin
            frame_err_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
          end
        end else if (tmr_tc_c) begin
          frame_err_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_SEND_H: state_d = ST_WAIT_H;
      ST_WAIT_H: begin
        if (tx_done_pulse) begin
          tx_start_d = 1'b1;
          tx_byte_d  = snap_q;
          state_d    = ST_SEND_D;
        end
      end
      ST_SEND_D: state_d = ST_WAIT_D;
      ST_WAIT_D: begin
        if (tx_done_pulse) begin
          tx_byte_d = 8'h00;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_cnt_d = err_cnt_q;
    if (frame_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hdr_q        <= '0;
      snap_q       <= '0;
      tx_start_q   <= 1'b0;
      tx_byte_q    <= '0;
      req_sala_q   <= '0;
      req_sensor_q <= '0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      snap_q       <= snap_d;
      tx_start_q   <= tx_start_d;
      tx_byte_q    <= tx_byte_d;
      req_sala_q   <= req_sala_d;
      req_sensor_q <= req_sensor_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_byte    = tx_byte_q;
  assign req_sala   = req_sala_q;
  assign req_sensor = req_sensor_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_sensor_req_responder.sv
// Directed self-checking bench for sensor_req_responder with a shortened inter-byte timeout.
module tb_sensor_req_responder;

  localparam int unsigned TMO = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_done_pulse = 1'b0;
  logic [7:0] s1_temp = 8'h1A, s1_hum = 8'h1B, s2_temp = 8'h2C, s2_hum = 8'h40;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic [1:0] req_sala, req_sensor;
  logic       busy, frame_err;
  logic [7:0] err_count;

  int n_chk = 0;
  int n_fail = 0;
  int tx_cnt = 0;

  sensor_req_responder #(.CLK_FREQ(25_000_000), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_done_pulse(tx_done_pulse), .s1_temp(s1_temp), .s1_hum(s1_hum),
    .s2_temp(s2_temp), .s2_hum(s2_hum), .tx_start(tx_start), .tx_byte(tx_byte),
    .req_sala(req_sala), .req_sensor(req_sensor), .busy(busy),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_start) tx_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic done_pulse();
    tx_done_pulse = 1'b1;
    tick();
    tx_done_pulse = 1'b0;
  endtask

  // Full valid request/reply exchange with header and data byte checks.
  task automatic exchange(input string tag, input logic [7:0] hdr, input logic [7:0] exp_data);
    int base;
    base = tx_cnt;
    send_byte(hdr);
    check({tag, "_busy_hdr"}, 32'(busy), 32'd1);
    send_byte(8'h00);
    check({tag, "_txs_h"}, 32'(tx_start), 32'd1);
    check({tag, "_txb_h"}, 32'(tx_byte), 32'(hdr));
    tick();
    check({tag, "_txs_1cyc"}, 32'(tx_start), 32'd0);
    tick();
    done_pulse();
    check({tag, "_txs_d"}, 32'(tx_start), 32'd1);
    check({tag, "_txb_d"}, 32'(tx_byte), 32'(exp_data));
    tick();
    check({tag, "_busy_mid"}, 32'(busy), 32'd1);
    done_pulse();
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_txb_idle"}, 32'(tx_byte), 32'h00);
    check({tag, "_ntx"}, 32'(tx_cnt - base), 32'd2);
  endtask

  task automatic bad_frame(input string tag, input logic [7:0] h, input logic [7:0] p);
    send_byte(h);
    send_byte(p);
    check({tag, "_ferr"}, 32'(frame_err), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_ferr_pulse"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    int base;
    int i;

    // Reset values
    #2;
    check("rst_txs", 32'(tx_start), 32'd0);
    check("rst_txb", 32'(tx_byte), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_errc", 32'(err_count), 32'd0);
    check("rst_req", 32'({req_sala, req_sensor}), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Room 1 temperature
    exchange("r1temp", 8'h05, 8'h1A);
    check("r1temp_sala", 32'(req_sala), 32'd1);
    check("r1temp_sens", 32'(req_sensor), 32'd1);

    // Room-only request answered with ack
    exchange("room2", 8'h02, 8'h00);
    check("room2_sala", 32'(req_sala), 32'd2);
    check("room2_sens", 32'(req_sensor), 32'd0);

    // Invalid frames
    base = tx_cnt;
    bad_frame("bad_nib", 8'h13, 8'h00);
    bad_frame("bad_sala", 8'h03, 8'h00);
    bad_frame("bad_pl", 8'h0A, 8'h55);
    check("bad_errc", 32'(err_count), 32'd3);
    check("bad_req", 32'({req_sala, req_sensor}), 32'h8);
    check("bad_notx", 32'(tx_cnt - base), 32'd0);

    // Timeout after header
    send_byte(8'h06);
    i = 0;
    while (i < 2 * TMO && !frame_err) begin
      tick();
      i++;
    end
    check("tmo_cycle", 32'(i), 32'(TMO));
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_errc", 32'(err_count), 32'd4);
    exchange("after_tmo", 8'h06, 8'h2C);

    // Snapshot isolation and dropped byte during reply
    base = tx_cnt;
    send_byte(8'h0A);
    send_byte(8'h00);
    s2_hum = 8'h41;
    tick();
    send_byte(8'h05);
    check("drop_ferr", 32'(frame_err), 32'd0);
    tick();
    done_pulse();
    check("snap_txb", 32'(tx_byte), 32'h40);
    tick();
    done_pulse();
    check("snap_busy", 32'(busy), 32'd0);
    check("snap_ntx", 32'(tx_cnt - base), 32'd2);
    check("snap_errc", 32'(err_count), 32'd4);

    // Reset while waiting for the data byte to finish
    send_byte(8'h05);
    send_byte(8'h00);
    tick();
    done_pulse();
    tick();
    check("rstwd_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstwd_txb", 32'(tx_byte), 32'h00);
    check("rstwd_busy", 32'(busy), 32'd0);
    check("rstwd_errc", 32'(err_count), 32'd0);
    check("rstwd_req", 32'({req_sala, req_sensor}), 32'h0);
    tick();
    rst_n = 1'b1;
    base = tx_cnt;
    tick();
    done_pulse();
    tick();
    tick();
    check("rstwd_notx", 32'(tx_cnt - base), 32'd0);
    check("rstwd_txs", 32'(tx_start), 32'd0);

    // Error counter saturation
    for (int k = 0; k < 300; k++) begin
      send_byte(8'h13);
      send_byte(8'h00);
      if (k == 253) check("sat_254", 32'(err_count), 32'd254);
      if (k == 254) check("sat_255", 32'(err_count), 32'd255);
    end
    tick();
    check("sat_hold", 32'(err_count), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
